fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage of the 5-stage pipelined MIPS core. Holds the PC and drives the
//  combinational instruction memory address. Captures the returned word into the IF/ID
//  pipeline register. Selects the next PC from:
//   - sequential PC+4
//   - ID-stage redirect (branch / j / jal / jr)
//   - interrupt vector
//   - exception vector
//  Handles stall/flush and reports the interrupt return address so downstream logic can write $k0.
// PARAMETERS
//  RESET_VECTOR  32'h8000_0000  PC after reset (kernel bit set, imem word 0)
//  IRQ_VECTOR    32'h8000_0004  interrupt entry (imem word 1)
//  EXC_VECTOR    32'h8000_0008  exception/error entry (imem word 2)
//  NOP_INSTR     32'h0000_0000  word injected into IF/ID on flush (sll $0,$0,0)
// PORTS
//  clk              in   1   system clock, all state on rising edge
//  reset            in   1   asynchronous, active-high reset
//  stall            in   1   hazard unit: hold PC and IF/ID
//  redirect         in   1   ID stage resolved taken branch/jump/jr this cycle
//  redirect_target  in   32  new PC for redirect (used verbatim; jr may clear bit 31)
//  exc_req          in   1   undefined-instruction/error exception request
//  irq              in   1   timer interrupt request, level-sensitive
//  imem_addr        out  32  instruction memory address (= pc)
//  imem_data        in   32  instruction word returned combinationally
//  pc               out  32  current fetch PC
//  if_id_instr      out  32  IF/ID instruction
//  if_id_pc_plus4   out  32  IF/ID PC+4 (for jal link / branch base)
//  if_id_valid      out  1   IF/ID holds a real instruction
//  irq_ack          out  1   one-cycle pulse: interrupt taken
//  epc              out  32  return address for $k0, valid when irq_ack=1
// BEHAVIOUR
//  Reset (async, immediate):
//   - pc=RESET_VECTOR, if_id_instr=NOP_INSTR, if_id_pc_plus4=0, if_id_valid=0
//   - irq_ack=0, epc=0
//  Supervisor bit:
//   - pc_plus4 = {pc[31], pc[30:0]+4}; bit 31 never changes by sequential fetch
//   - bit 31 changes only via vectors (set) or redirect_target (jr clears it)
//  irq_take = irq & ~pc[31] & ~stall & ~exc_req
//   - masked in kernel mode, deferred while stalled
//  Next-state priority per rising edge (highest first):
//   1 exc_req  : pc<=EXC_VECTOR; IF/ID<=flush (NOP_INSTR, valid=0); irq_ack<=0.
//   2 irq_take : pc<=IRQ_VECTOR; IF/ID<=flush; irq_ack<=1;
//                epc <= redirect ? redirect_target : pc (flushed instr re-fetched on return).
//   3 redirect : pc<=redirect_target; IF/ID<=flush (instruction in IF discarded; no delay slot).
//   4 stall    : pc, IF/ID, epc unchanged; irq_ack<=0.
//   5 else     : pc<=pc_plus4; if_id_instr<=imem_data; if_id_pc_plus4<=pc_plus4; if_id_valid<=1.
//  Redirect and stall together:
//   - redirect wins; hazard unit never stalls IF on an ID redirect
//   - redirect wins anyway for safety
//  Latency:
//   - imem_addr=pc combinationally; instruction appears in IF/ID one edge later
//   - redirect/vector target is fetched the cycle after the edge that loads it (1-cycle bubble)
//  Other rules:
//   - irq_ack high exactly one cycle per taken interrupt
//   - held irq is not retaken while pc[31]=1 (handler runs to jr $k0)
//   - flush writes valid=0 and NOP_INSTR together; downstream treats valid=0 as a bubble
//   - 32-bit PC adder wraps mod 2^31 within bit 31's half; no overflow flag
// TESTING
//  1 Reset, release, 4 cycles no events:
//    -> pc 8000_0000,..04,..08,..0C
//    -> if_id_pc_plus4 tracks pc+4, valid=1 from cycle 2
//  2 pc=0000_0044, redirect=1, target=0000_0068:
//    -> next pc=0000_0068; IF/ID = NOP, valid=0
//    -> following edge loads imem[0x68]
//  3 pc=0000_0080 user, irq=1:
//    -> pc=8000_0004, irq_ack=1 one cycle, epc=0000_0080
//    -> irq kept high while pc[31]=1: no second ack
//    -> redirect to 0000_0080 (jr $k0) resumes fetch there
//  4 irq=1 with stall=1 for 3 cycles:
//    -> pc and IF/ID frozen, no ack
//    -> ack on first unstalled edge
//  5 exc_req=1 together with irq=1 and redirect=1:
//    -> pc=8000_0008, irq_ack=0, IF/ID flushed
//  6 reset asserted mid-cycle during stall:
//    -> outputs immediately return to reset values without waiting for clk

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction-fetch stage holding the PC and the IF/ID pipeline register.
// Ports:
//   clk, reset (async, active-high)
//   stall            hold PC and IF/ID
//   redirect         ID-stage taken branch/jump; redirect_target is the new PC
//   exc_req          exception request, vectors to EXC_VECTOR
//   irq              level-sensitive interrupt, taken only in user mode (pc[31]=0)
//   imem_addr/data   combinational instruction memory interface
//   pc               current fetch PC
//   if_id_*          IF/ID register: instruction, PC+4, valid
//   irq_ack, epc     one-cycle interrupt-taken pulse and return address
module fetch_stage #(
    parameter logic [31:0] RESET_VECTOR = 32'h8000_0000,
    parameter logic [31:0] IRQ_VECTOR   = 32'h8000_0004,
    parameter logic [31:0] EXC_VECTOR   = 32'h8000_0008,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic        exc_req,
    input  logic        irq,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        irq_ack,
    output logic [31:0] epc
);
    logic [31:0] pc_plus4, pc_n, instr_n, pc4_n, epc_n;
    logic        irq_take, flush, valid_n;
    // Sequential fetch never touches the supervisor bit; only vectors or redirects do.
    assign pc_plus4  = {pc[31], pc[30:0] + 31'd4};
    assign irq_take  = irq & ~pc[31] & ~stall & ~exc_req;
    assign flush     = exc_req | irq_take | redirect;
    assign imem_addr = pc;
    always_comb begin
        pc_n    = exc_req ? EXC_VECTOR : irq_take ? IRQ_VECTOR : redirect ? redirect_target :
                  stall ? pc : pc_plus4;
        instr_n = flush ? NOP_INSTR : stall ? if_id_instr : imem_data;
        pc4_n   = (flush | stall) ? if_id_pc_plus4 : pc_plus4;
        valid_n = flush ? 1'b0 : stall ? if_id_valid : 1'b1;
        // A redirect taken on the same edge is squashed, so return to its target instead.
        epc_n   = irq_take ? (redirect ? redirect_target : pc) : epc;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc             <= RESET_VECTOR;
            if_id_instr    <= NOP_INSTR;
            if_id_pc_plus4 <= 32'h0;
            if_id_valid    <= 1'b0;
            irq_ack        <= 1'b0;
            epc            <= 32'h0;
        end else begin
            pc             <= pc_n;
            if_id_instr    <= instr_n;
            if_id_pc_plus4 <= pc4_n;
            if_id_valid    <= valid_n;
            irq_ack        <= irq_take;
            epc            <= epc_n;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scoreboard bench for fetch_stage.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        reset, stall, redirect, exc_req, irq;
    logic [31:0] redirect_target, imem_addr, imem_data, pc, if_id_instr, if_id_pc_plus4, epc;
    logic        if_id_valid, irq_ack;
    int          tests = 0, fails = 0;

    typedef struct {
        string       tag;
        logic [31:0] pc, instr, pc4;
        logic        valid, ack;
        logic [31:0] epc;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5A5, a[15:0] ^ 16'h1234};
    endfunction
    assign imem_data = imem(imem_addr);

    fetch_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_target(redirect_target), .exc_req(exc_req), .irq(irq),
        .imem_addr(imem_addr), .imem_data(imem_data), .pc(pc),
        .if_id_instr(if_id_instr), .if_id_pc_plus4(if_id_pc_plus4),
        .if_id_valid(if_id_valid), .irq_ack(irq_ack), .epc(epc)
    );

    task automatic expect_state(input string tag, input logic [31:0] p, input logic [31:0] i,
                                input logic [31:0] p4, input logic v, input logic a,
                                input logic [31:0] e);
        exp_t x;
        x.tag = tag; x.pc = p; x.instr = i; x.pc4 = p4; x.valid = v; x.ack = a; x.epc = e;
        q.push_back(x);
    endtask

    task automatic check_now();
        exp_t e;
        e = q.pop_front();
        tests++;
        assert (pc === e.pc) else begin fails++; $error("FAIL %s pc got %h exp %h", e.tag, pc, e.pc); end
        tests++;
        assert (imem_addr === e.pc) else begin fails++; $error("FAIL %s imem_addr got %h exp %h", e.tag, imem_addr, e.pc); end
        tests++;
        assert (if_id_instr === e.instr) else begin fails++; $error("FAIL %s instr got %h exp %h", e.tag, if_id_instr, e.instr); end
        tests++;
        assert (if_id_pc_plus4 === e.pc4) else begin fails++; $error("FAIL %s pc4 got %h exp %h", e.tag, if_id_pc_plus4, e.pc4); end
        tests++;
        assert (if_id_valid === e.valid) else begin fails++; $error("FAIL %s valid got %b exp %b", e.tag, if_id_valid, e.valid); end
        tests++;
        assert (irq_ack === e.ack) else begin fails++; $error("FAIL %s irq_ack got %b exp %b", e.tag, irq_ack, e.ack); end
        tests++;
        assert (epc === e.epc) else begin fails++; $error("FAIL %s epc got %h exp %h", e.tag, epc, e.epc); end
    endtask

    task automatic edge_check();
        @(posedge clk);
        #1;
        check_now();
    endtask

    task automatic drive(input logic s, input logic r, input logic [31:0] t, input logic x, input logic i);
        stall = s; redirect = r; redirect_target = t; exc_req = x; irq = i;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 32'h0, 0, 0);
        #1;
        expect_state("reset", 32'h8000_0000, 32'h0, 32'h0, 0, 0, 32'h0);
        check_now();
        @(negedge clk);
        reset = 1'b0;
        // sequential fetch from the reset vector
        expect_state("seq1", 32'h8000_0004, imem(32'h8000_0000), 32'h8000_0004, 1, 0, 32'h0); edge_check();
        expect_state("seq2", 32'h8000_0008, imem(32'h8000_0004), 32'h8000_0008, 1, 0, 32'h0); edge_check();
        expect_state("seq3", 32'h8000_000C, imem(32'h8000_0008), 32'h8000_000C, 1, 0, 32'h0); edge_check();
        // jump into user space, then branch redirect
        drive(0, 1, 32'h0000_0044, 0, 0);
        expect_state("jr_user", 32'h0000_0044, 32'h0, 32'h8000_000C, 0, 0, 32'h0); edge_check();
        drive(0, 1, 32'h0000_0068, 0, 0);
        expect_state("redir", 32'h0000_0068, 32'h0, 32'h8000_000C, 0, 0, 32'h0); edge_check();
        drive(0, 0, 32'h0, 0, 0);
        expect_state("redir_fetch", 32'h0000_006C, imem(32'h0000_0068), 32'h0000_006C, 1, 0, 32'h0); edge_check();
        // interrupt from user mode at 0x80
        drive(0, 1, 32'h0000_0080, 0, 0);
        expect_state("to80", 32'h0000_0080, 32'h0, 32'h0000_006C, 0, 0, 32'h0); edge_check();
        drive(0, 0, 32'h0, 0, 1);
        expect_state("irq_take", 32'h8000_0004, 32'h0, 32'h0000_006C, 0, 1, 32'h0000_0080); edge_check();
        expect_state("irq_masked1", 32'h8000_0008, imem(32'h8000_0004), 32'h8000_0008, 1, 0, 32'h0000_0080); edge_check();
        expect_state("irq_masked2", 32'h8000_000C, imem(32'h8000_0008), 32'h8000_000C, 1, 0, 32'h0000_0080); edge_check();
        drive(0, 1, 32'h0000_0080, 0, 0);
        expect_state("eret", 32'h0000_0080, 32'h0, 32'h8000_000C, 0, 0, 32'h0000_0080); edge_check();
        drive(0, 0, 32'h0, 0, 0);
        expect_state("resume", 32'h0000_0084, imem(32'h0000_0080), 32'h0000_0084, 1, 0, 32'h0000_0080); edge_check();
        // interrupt deferred by stall
        drive(1, 0, 32'h0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            expect_state("stall_irq", 32'h0000_0084, imem(32'h0000_0080), 32'h0000_0084, 1, 0, 32'h0000_0080);
            edge_check();
        end
        drive(0, 0, 32'h0, 0, 1);
        expect_state("irq_after_stall", 32'h8000_0004, 32'h0, 32'h0000_0084, 0, 1, 32'h0000_0084); edge_check();
        drive(0, 1, 32'h0000_0084, 0, 0);
        expect_state("eret2", 32'h0000_0084, 32'h0, 32'h0000_0084, 0, 0, 32'h0000_0084); edge_check();
        drive(0, 0, 32'h0, 0, 0);
        expect_state("resume2", 32'h0000_0088, imem(32'h0000_0084), 32'h0000_0088, 1, 0, 32'h0000_0084); edge_check();
        // exception beats irq and redirect
        drive(0, 1, 32'h0000_0200, 1, 1);
        expect_state("exc", 32'h8000_0008, 32'h0, 32'h0000_0088, 0, 0, 32'h0000_0084); edge_check();
        drive(0, 0, 32'h0, 0, 0);
        expect_state("exc_fetch", 32'h8000_000C, imem(32'h8000_0008), 32'h8000_000C, 1, 0, 32'h0000_0084); edge_check();
        // async reset during stall
        drive(1, 0, 32'h0, 0, 0);
        expect_state("stall_hold", 32'h8000_000C, imem(32'h8000_0008), 32'h8000_000C, 1, 0, 32'h0000_0084); edge_check();
        #2;
        reset = 1'b1;
        #1;
        expect_state("async_reset", 32'h8000_0000, 32'h0, 32'h0, 0, 0, 32'h0);
        check_now();
        @(negedge clk);
        reset = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
